// File: rtl/user_input_irq_ctrl_if.sv
// Avalon-MM slave bus for the user input interrupt controller.
// The host drives the master side and the controller drives the slave side.
interface user_input_irq_ctrl_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, read, write, writedata, input  readdata, irq);
    modport slave  (input  address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/user_input_irq_ctrl.sv
// Debounced key/switch inputs with per-bit edge capture, mask and global enable,
// exposed as a 4-register Avalon-MM slave with a level interrupt.
module user_input_irq_ctrl #(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SWITCHES    = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit CLEAR_ON_READ   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_KEYS-1:0]     keys,
    input  logic [NUM_SWITCHES-1:0] switches,
    user_input_irq_ctrl_if.slave    avl
);
    localparam int N      = NUM_KEYS + NUM_SWITCHES;
    localparam int CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SETTLE = DEBOUNCE_CYCLES + 3;
    localparam int SW     = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        REG_STATE   = 2'd0,
        REG_CAPTURE = 2'd1,
        REG_MASK    = 2'd2,
        REG_CONTROL = 2'd3
    } reg_addr_e;

    logic [N-1:0]  pins;
    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  stable;
    logic [N-1:0]  change;
    logic [N-1:0]  capture;
    logic [N-1:0]  capture_next;
    logic [N-1:0]  w1c_bits;
    logic [N-1:0]  mask;
    logic [CW-1:0] cnt [N];
    logic [SW-1:0] settle_cnt;
    logic          enable;
    logic          primed;
    logic          clear_on_read;
    logic [31:0]   read_value;
    reg_addr_e     addr;
    logic          unused_wdata;

    // Keys are active-low on the board; present every input as 1 = active.
    assign pins         = {switches, ~keys};
    assign addr         = reg_addr_e'(avl.address);
    assign unused_wdata = ^avl.writedata;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes the sync chain work.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    // NOTE: the debounce counters form a small register array, so they are reset
    // explicitly; a real memory would normally be left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        change = '0;
        for (int i = 0; i < N; i++) begin
            change[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // Capture stays blind until the inputs have had time to settle after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_cnt <= '0;
            primed     <= 1'b0;
        end else if (!primed) begin
            if (settle_cnt == SETTLE_MAX) primed <= 1'b1;
            else                          settle_cnt <= settle_cnt + 1'b1;
        end
    end

    always_comb begin
        w1c_bits      = '0;
        clear_on_read = 1'b0;
        if (avl.write && addr == REG_CAPTURE) w1c_bits = avl.writedata[N-1:0];
        if (CLEAR_ON_READ && avl.read && addr == REG_STATE) clear_on_read = 1'b1;
        // A new edge in the same cycle as a clear must not be lost.
        capture_next = (capture & ~w1c_bits & ~{N{clear_on_read}}) | (change & {N{primed}});
    end

    always_comb begin
        read_value = '0;
        unique case (addr)
            REG_STATE:   read_value[N-1:0] = stable;
            REG_CAPTURE: read_value[N-1:0] = capture;
            REG_MASK:    read_value[N-1:0] = mask;
            REG_CONTROL: read_value[1:0]   = {primed, enable};
            default:     read_value        = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            capture      <= '0;
            mask         <= '1;
            enable       <= 1'b1;
            avl.readdata <= '0;
            avl.irq      <= 1'b0;
        end else begin
            capture <= capture_next;
            if (avl.write && addr == REG_MASK)    mask   <= avl.writedata[N-1:0];
            if (avl.write && addr == REG_CONTROL) enable <= avl.writedata[0];
            if (avl.read)                         avl.readdata <= read_value;
            avl.irq <= enable & |(capture & mask);
        end
    end
endmodule

// File: tb/tb_user_input_irq_ctrl.sv
// Scoreboard bench: one instance in clear-on-read mode, one in W1C-only mode,
// both driven from the same key/switch pins.
module tb_user_input_irq_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] keys = 4'b1111;
    logic [3:0] switches = 4'b0000;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    user_input_irq_ctrl_if a0 ();
    user_input_irq_ctrl_if a1 ();

    user_input_irq_ctrl #(.NUM_KEYS(4), .NUM_SWITCHES(4), .DEBOUNCE_CYCLES(4), .CLEAR_ON_READ(1'b1)) u_cor (
        .clk(clk), .reset(reset), .keys(keys), .switches(switches), .avl(a0));
    user_input_irq_ctrl #(.NUM_KEYS(4), .NUM_SWITCHES(4), .DEBOUNCE_CYCLES(4), .CLEAR_ON_READ(1'b0)) u_w1c (
        .clk(clk), .reset(reset), .keys(keys), .switches(switches), .avl(a1));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input int sel, input bit do_rd, input bit do_wr, input logic [1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, input string tag);
        logic [31:0] got;
        if (sel == 0) begin
            a0.address = addr; a0.read = do_rd; a0.write = do_wr; a0.writedata = wdata;
        end else begin
            a1.address = addr; a1.read = do_rd; a1.write = do_wr; a1.writedata = wdata;
        end
        if (do_rd) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        step();
        a0.read = 1'b0; a0.write = 1'b0;
        a1.read = 1'b0; a1.write = 1'b0;
        if (do_rd) begin
            got = (sel == 0) ? a0.readdata : a1.readdata;
            check(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    task automatic rd(input int sel, input logic [1:0] addr, input logic [31:0] exp, input string tag);
        bus(sel, 1'b1, 1'b0, addr, 32'h0, exp, tag);
    endtask

    task automatic wr(input int sel, input logic [1:0] addr, input logic [31:0] wdata);
        bus(sel, 1'b0, 1'b1, addr, wdata, 32'h0, "");
    endtask

    initial begin
        int irq_seen;
        a0.address = '0; a0.read = 1'b0; a0.write = 1'b0; a0.writedata = '0;
        a1.address = '0; a1.read = 1'b0; a1.write = 1'b0; a1.writedata = '0;

        // Reset and idle
        step(3);
        check("rst_rdata", a0.readdata, 32'h0);
        check("rst_irq", {31'b0, a0.irq}, 32'h0);
        reset = 1'b1;
        step(10);
        check("idle_irq", {31'b0, a0.irq}, 32'h0);
        rd(0, 2'd3, 32'h3, "idle_ctrl");
        rd(0, 2'd2, 32'hFF, "idle_mask");

        // Switch edge: irq exactly 7 cycles after the pin changes
        switches = 4'b0001;
        step(6);
        check("sw_irq_early", {31'b0, a0.irq}, 32'h0);
        step();
        check("sw_irq_on", {31'b0, a0.irq}, 32'h1);
        rd(0, 2'd1, 32'h10, "sw_capture");
        rd(0, 2'd0, 32'h10, "sw_state_cor");
        step();
        check("cor_irq_off", {31'b0, a0.irq}, 32'h0);
        rd(0, 2'd1, 32'h0, "cor_capture");
        switches = 4'b0000;
        step(8);
        check("sw_rel_irq", {31'b0, a0.irq}, 32'h1);
        rd(0, 2'd1, 32'h10, "sw_rel_capture");
        rd(0, 2'd0, 32'h0, "sw_rel_state");

        // Key press and W1C on the W1C-only instance
        wr(1, 2'd1, 32'hFF);
        step();
        check("w1c_pre_irq", {31'b0, a1.irq}, 32'h0);
        keys = 4'b1101;
        step(8);
        check("key_irq", {31'b0, a1.irq}, 32'h1);
        rd(1, 2'd0, 32'h02, "key_state");
        rd(1, 2'd1, 32'h02, "key_capture_no_cor");
        wr(1, 2'd1, 32'h01);
        step();
        check("w1c_other_irq", {31'b0, a1.irq}, 32'h1);
        rd(1, 2'd1, 32'h02, "w1c_other_capture");
        wr(1, 2'd1, 32'h02);
        step();
        check("w1c_irq_off", {31'b0, a1.irq}, 32'h0);
        rd(1, 2'd1, 32'h0, "w1c_capture");
        keys = 4'b1111;
        step(8);
        rd(0, 2'd0, 32'h0, "key_rel_state");
        wr(1, 2'd1, 32'hFF);
        step(2);

        // Glitch rejection: 3-cycle pulse on key 0
        keys = 4'b1110;
        step(3);
        keys = 4'b1111;
        irq_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a0.irq || a1.irq) irq_seen++;
        end
        check("glitch_irq", irq_seen, 0);
        rd(0, 2'd0, 32'h0, "glitch_state");
        rd(0, 2'd1, 32'h0, "glitch_capture");

        // Masking and enable; simultaneous read/write returns the old mask
        bus(0, 1'b1, 1'b1, 2'd2, 32'hEF, 32'hFF, "rdwr_mask");
        rd(0, 2'd2, 32'hEF, "mask_written");
        switches = 4'b0001;
        step(8);
        rd(0, 2'd1, 32'h10, "masked_capture");
        check("masked_irq", {31'b0, a0.irq}, 32'h0);
        wr(0, 2'd2, 32'hFF);
        step();
        check("unmasked_irq", {31'b0, a0.irq}, 32'h1);
        wr(0, 2'd3, 32'h0);
        step();
        check("disabled_irq", {31'b0, a0.irq}, 32'h0);
        rd(0, 2'd1, 32'h10, "disabled_capture");
        rd(0, 2'd3, 32'h2, "disabled_ctrl");
        wr(0, 2'd3, 32'h1);
        step();
        check("enabled_irq", {31'b0, a0.irq}, 32'h1);

        // Collision: W1C lands on the same edge as a new bit-4 change pulse
        switches = 4'b0000;
        step(5);
        wr(0, 2'd1, 32'h10);
        rd(0, 2'd1, 32'h10, "collision_capture");
        rd(0, 2'd0, 32'h0, "collision_state");

        // Priming: switch held on through reset raises no interrupt
        reset = 1'b0;
        switches = 4'b1000;
        step(3);
        check("rst2_rdata", a0.readdata, 32'h0);
        check("rst2_irq", {31'b0, a0.irq}, 32'h0);
        reset = 1'b1;
        step(2);
        rd(0, 2'd3, 32'h1, "settling_ctrl");
        step(8);
        rd(0, 2'd3, 32'h3, "primed_ctrl");
        rd(0, 2'd1, 32'h0, "primed_capture");
        rd(1, 2'd1, 32'h0, "primed_capture_w1c");
        rd(0, 2'd0, 32'h80, "primed_state");
        check("primed_irq", {31'b0, a0.irq}, 32'h0);

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
